// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART core with a shared oversampling tick, a
// valid/ready transmitter and a majority-voting receiver with error reporting.
module uart_core_param #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] SMP0      = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] SMP1      = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] SMP2      = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  logic [DW-1:0] r_div_cnt;
  logic          w_tick;
  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_div_cnt <= '0;
    else               r_div_cnt <= r_div_cnt + 1'b1;
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            r_tx_state, w_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic                 r_tx_par, w_tx_par;
  logic [OW-1:0]        r_tx_tcnt, w_tx_tcnt;
  logic [3:0]           r_tx_bcnt, w_tx_bcnt;
  logic                 r_txd, w_txd;
  logic                 w_tx_bit_end;
  assign w_tx_bit_end = w_tick && (r_tx_tcnt == OS_LAST);

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_shift = r_tx_shift;
    w_tx_par   = r_tx_par;
    w_tx_tcnt  = r_tx_tcnt;
    w_tx_bcnt  = r_tx_bcnt;
    w_txd      = r_txd;
    if (r_tx_state != TX_IDLE && w_tick)
      w_tx_tcnt = w_tx_bit_end ? '0 : r_tx_tcnt + 1'b1;
    case (r_tx_state)
      TX_IDLE: if (tx_valid) begin
        w_tx_state = TX_START;
        w_tx_shift = tx_data;
        w_tx_par   = (^tx_data) ^ PAR_ODD;
        w_tx_tcnt  = '0;
        w_tx_bcnt  = '0;
        w_txd      = 1'b0;
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_state = TX_DATA;
        w_txd      = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_bit_end) begin
        w_tx_shift = r_tx_shift >> 1;
        if (r_tx_bcnt == DATA_LAST) begin
          w_tx_bcnt = '0;
          if (PARITY != 0) begin
            w_tx_state = TX_PARITY;
            w_txd      = r_tx_par;
          end else begin
            w_tx_state = TX_STOP;
            w_txd      = 1'b1;
          end
        end else begin
          w_tx_bcnt = r_tx_bcnt + 1'b1;
          w_txd     = r_tx_shift[1];
        end
      end
      TX_PARITY: if (w_tx_bit_end) begin
        w_tx_state = TX_STOP;
        w_txd      = 1'b1;
      end
      TX_STOP: if (w_tx_bit_end) begin
        if (r_tx_bcnt == STOP_LAST) w_tx_state = TX_IDLE;
        else                        w_tx_bcnt  = r_tx_bcnt + 1'b1;
      end
      default: w_tx_state = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_shift <= w_tx_shift;
      r_tx_par   <= w_tx_par;
      r_tx_tcnt  <= w_tx_tcnt;
      r_tx_bcnt  <= w_tx_bcnt;
      r_txd      <= w_txd;
    end
  end

  assign tx_ready = (r_tx_state == TX_IDLE);
  assign txd      = r_txd;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  rx_state_t            r_rx_state, w_rx_state;
  logic [1:0]           r_rx_sync;
  logic [OW-1:0]        r_rx_tcnt, w_rx_tcnt, w_rx_idx;
  logic [1:0]           r_rx_smp, w_rx_smp;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
  logic [3:0]           r_rx_bcnt, w_rx_bcnt;
  logic                 r_rx_perr, w_rx_perr, r_rx_ferr, w_rx_ferr, r_rx_done, w_rx_done;
  logic                 w_rxs, w_rx_bit, w_rx_decide;

  assign w_rxs       = r_rx_sync[1];
  // Tick index within the current bit; the start-detect tick is index 0.
  assign w_rx_idx    = (r_rx_tcnt == OS_LAST) ? '0 : r_rx_tcnt + 1'b1;
  assign w_rx_bit    = (r_rx_smp[0] & r_rx_smp[1]) | (r_rx_smp[0] & w_rxs) | (r_rx_smp[1] & w_rxs);
  assign w_rx_decide = w_tick && (w_rx_idx == SMP2);

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_tcnt  = r_rx_tcnt;
    w_rx_smp   = r_rx_smp;
    w_rx_shift = r_rx_shift;
    w_rx_bcnt  = r_rx_bcnt;
    w_rx_perr  = r_rx_perr;
    w_rx_ferr  = r_rx_ferr;
    w_rx_done  = 1'b0;
    if (w_tick && r_rx_state != RX_IDLE && r_rx_state != RX_WAIT_HIGH) begin
      w_rx_tcnt = w_rx_idx;
      if (w_rx_idx == SMP0) w_rx_smp[0] = w_rxs;
      if (w_rx_idx == SMP1) w_rx_smp[1] = w_rxs;
    end
    case (r_rx_state)
      RX_IDLE: if (w_tick && !w_rxs) begin
        w_rx_state = RX_START;
        w_rx_tcnt  = '0;
        w_rx_bcnt  = '0;
        w_rx_perr  = 1'b0;
        w_rx_ferr  = 1'b0;
      end
      RX_START: if (w_rx_decide) w_rx_state = w_rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA: if (w_rx_decide) begin
        w_rx_shift = {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
        if (r_rx_bcnt == DATA_LAST) w_rx_state = (PARITY != 0) ? RX_PARITY : RX_STOP;
        else                        w_rx_bcnt  = r_rx_bcnt + 1'b1;
      end
      RX_PARITY: if (w_rx_decide) begin
        w_rx_perr  = w_rx_bit ^ (^r_rx_shift) ^ PAR_ODD;
        w_rx_state = RX_STOP;
      end
      // Decide at mid stop bit so a following start edge is not missed.
      RX_STOP: if (w_rx_decide) begin
        w_rx_ferr  = !w_rx_bit;
        w_rx_done  = 1'b1;
        w_rx_state = w_rx_bit ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (w_tick && w_rxs) w_rx_state = RX_IDLE;
      default: w_rx_state = RX_IDLE;
    endcase
  end

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_rx_ferr_out, r_rx_perr_out, r_rx_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_smp   <= '0;
      r_rx_shift <= '0;
      r_rx_bcnt  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], rxd};
      r_rx_state <= w_rx_state;
      r_rx_tcnt  <= w_rx_tcnt;
      r_rx_smp   <= w_rx_smp;
      r_rx_shift <= w_rx_shift;
      r_rx_bcnt  <= w_rx_bcnt;
      r_rx_perr  <= w_rx_perr;
      r_rx_ferr  <= w_rx_ferr;
      r_rx_done  <= w_rx_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_ferr_out <= 1'b0;
      r_rx_perr_out <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else if (r_rx_done) begin
      if (!r_rx_valid || rx_ack) begin
        r_rx_data     <= r_rx_shift;
        r_rx_valid    <= 1'b1;
        r_rx_ferr_out <= r_rx_ferr;
        r_rx_perr_out <= r_rx_perr;
        r_rx_overrun  <= 1'b0;
      end else begin
        r_rx_overrun  <= 1'b1;
      end
    end else if (rx_ack && r_rx_valid) begin
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_frame_err  = r_rx_ferr_out;
  assign rx_parity_err = r_rx_perr_out;
  assign rx_overrun    = r_rx_overrun;
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed bench for an 8N1 and a 7E2 instance of uart_core_param.
`timescale 1ns/1ps
module tb_uart_core_param;
  localparam int CLKF = 1600000;
  localparam int BR   = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_tx_data = '0;
  logic       a_tx_valid = 1'b0, a_rx_ack = 1'b0, a_rxd_drv = 1'b1, a_loop = 1'b0;
  logic       a_tx_ready, a_txd, a_rxd, a_rx_valid, a_ferr, a_perr, a_ovr;
  logic [7:0] a_rx_data;
  assign a_rxd = a_loop ? a_txd : a_rxd_drv;

  logic [6:0] b_tx_data = '0;
  logic       b_tx_valid = 1'b0, b_rx_ack = 1'b0, b_rxd_drv = 1'b1, b_loop = 1'b0;
  logic       b_tx_ready, b_txd, b_rxd, b_rx_valid, b_ferr, b_perr, b_ovr;
  logic [6:0] b_rx_data;
  assign b_rxd = b_loop ? b_txd : b_rxd_drv;

  uart_core_param #(.CLK_FREQ(CLKF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .txd(a_txd), .rxd(a_rxd), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ack(a_rx_ack),
    .rx_frame_err(a_ferr), .rx_parity_err(a_perr), .rx_overrun(a_ovr));

  uart_core_param #(.CLK_FREQ(CLKF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .txd(b_txd), .rxd(b_rxd), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ack(b_rx_ack),
    .rx_frame_err(b_ferr), .rx_parity_err(b_perr), .rx_overrun(b_ovr));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] f8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // Start a transfer, then sample txd mid-bit and count tx_ready-low cycles.
  task automatic tx_and_watch(input int sel, input logic [7:0] data, input logic [15:0] exp_bits,
                              input int nbits, input int exp_busy, input string tag);
    int busy;
    logic [15:0] got_bits;
    logic t, r;
    busy = 0;
    got_bits = '0;
    @(negedge clk);
    if (sel == 0) begin a_tx_data = data; a_tx_valid = 1'b1; end
    else begin b_tx_data = data[6:0]; b_tx_valid = 1'b1; end
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    for (int n = 1; n <= exp_busy + 8; n++) begin
      @(negedge clk);
      t = (sel == 0) ? a_txd : b_txd;
      r = (sel == 0) ? a_tx_ready : b_tx_ready;
      if (!r) busy++;
      if ((n % 16) == 8 && (n / 16) < nbits) got_bits[n / 16] = t;
    end
    $display("tx %s data=0x%0h bits=0x%0h busy=%0d", tag, data, got_bits, busy);
    check_eq({tag, "_txd"}, {16'h0, got_bits}, {16'h0, exp_bits});
    check_eq({tag, "_busy"}, busy, exp_busy);
  endtask

  // Drive a frame onto rxd, 16 clk per bit; optional 1-clk spike mid-bit.
  task automatic drive_line(input int sel, input logic [15:0] bits, input int n, input int spike_bit);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 16; c++) begin
        if (sel == 0) a_rxd_drv = (i == spike_bit && c == 8) ? ~bits[i] : bits[i];
        else          b_rxd_drv = (i == spike_bit && c == 8) ? ~bits[i] : bits[i];
        @(negedge clk);
      end
    end
  endtask

  task automatic ack(input int sel);
    @(negedge clk);
    if (sel == 0) a_rx_ack = 1'b1; else b_rx_ack = 1'b1;
    @(negedge clk);
    a_rx_ack = 1'b0;
    b_rx_ack = 1'b0;
  endtask

  task automatic check_rx_a(input string tag, input logic [7:0] d, input logic fe,
                            input logic pe, input logic ov);
    $display("rx %s data=0x%0h valid=%0b fe=%0b pe=%0b ov=%0b", tag, a_rx_data, a_rx_valid,
             a_ferr, a_perr, a_ovr);
    check_eq({tag, "_valid"}, {31'h0, a_rx_valid}, 32'h1);
    check_eq({tag, "_data"}, {24'h0, a_rx_data}, {24'h0, d});
    check_eq({tag, "_ferr"}, {31'h0, a_ferr}, {31'h0, fe});
    check_eq({tag, "_perr"}, {31'h0, a_perr}, {31'h0, pe});
    check_eq({tag, "_ovr"}, {31'h0, a_ovr}, {31'h0, ov});
  endtask

  initial begin
    int cnt;
    logic fe_seen;
    logic [7:0] brk_data;

    repeat (4) @(negedge clk);
    check_eq("rst_txd", {31'h0, a_txd}, 32'h1);
    check_eq("rst_ready", {31'h0, a_tx_ready}, 32'h1);
    check_eq("rst_valid", {31'h0, a_rx_valid}, 32'h0);
    check_eq("rst_data", {24'h0, a_rx_data}, 32'h0);
    check_eq("rst_errs", {29'h0, a_ferr, a_perr, a_ovr}, 32'h0);
    check_eq("rst_b_ready", {31'h0, b_tx_ready}, 32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 loopback
    a_loop = 1'b1;
    tx_and_watch(0, 8'hA5, 16'h034A, 10, 160, "t1");
    check_rx_a("t1_rx", 8'hA5, 1'b0, 1'b0, 1'b0);
    a_loop = 1'b0;
    ack(0);
    check_eq("t1_ack_valid", {31'h0, a_rx_valid}, 32'h0);

    // 7E2 loopback, then a frame with the parity bit flipped
    b_loop = 1'b1;
    tx_and_watch(1, 8'h53, {5'b0, 2'b11, 1'b0, 7'h53, 1'b0}, 11, 176, "t2");
    check_eq("t2_valid", {31'h0, b_rx_valid}, 32'h1);
    check_eq("t2_data", {25'h0, b_rx_data}, 32'h53);
    check_eq("t2_perr", {31'h0, b_perr}, 32'h0);
    check_eq("t2_ferr", {31'h0, b_ferr}, 32'h0);
    b_loop = 1'b0;
    ack(1);
    drive_line(1, {5'b0, 2'b11, 1'b1, 7'h53, 1'b0}, 11, -1);
    $display("rx t2b data=0x%0h pe=%0b", b_rx_data, b_perr);
    check_eq("t2b_valid", {31'h0, b_rx_valid}, 32'h1);
    check_eq("t2b_data", {25'h0, b_rx_data}, 32'h53);
    check_eq("t2b_perr", {31'h0, b_perr}, 32'h1);
    check_eq("t2b_ovr", {31'h0, b_ovr}, 32'h0);
    ack(1);

    // short glitch, then a frame with a 1-clk spike inside data bit 0
    @(negedge clk);
    a_rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    a_rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    $display("rx t3 glitch valid=%0b", a_rx_valid);
    check_eq("t3_glitch_valid", {31'h0, a_rx_valid}, 32'h0);
    drive_line(0, f8(8'h96), 10, 1);
    check_rx_a("t3_spike", 8'h96, 1'b0, 1'b0, 1'b0);
    ack(0);

    // stop bit low, then a long break, then a clean frame
    drive_line(0, {6'b0, 1'b0, 8'h5A, 1'b0}, 10, -1);
    a_rxd_drv = 1'b1;
    repeat (32) @(negedge clk);
    check_rx_a("t4_frame", 8'h5A, 1'b1, 1'b0, 1'b0);
    ack(0);
    cnt = 0;
    fe_seen = 1'b0;
    brk_data = 8'hFF;
    a_rxd_drv = 1'b0;
    for (int n = 0; n < 1664; n++) begin
      if (n == 1600) a_rxd_drv = 1'b1;
      @(negedge clk);
      if (a_rx_ack) a_rx_ack = 1'b0;
      else if (a_rx_valid) begin
        cnt++;
        fe_seen = a_ferr;
        brk_data = a_rx_data;
        a_rx_ack = 1'b1;
      end
    end
    a_rx_ack = 1'b0;
    @(negedge clk);
    $display("rx t4 break deliveries=%0d fe=%0b data=0x%0h", cnt, fe_seen, brk_data);
    check_eq("t4_break_count", cnt, 1);
    check_eq("t4_break_ferr", {31'h0, fe_seen}, 32'h1);
    check_eq("t4_break_data", {24'h0, brk_data}, 32'h0);
    drive_line(0, f8(8'h3C), 10, -1);
    check_rx_a("t4_clean", 8'h3C, 1'b0, 1'b0, 1'b0);
    ack(0);

    // overrun, ack clears it, ack coinciding with a delivery
    drive_line(0, f8(8'h11), 10, -1);
    drive_line(0, f8(8'h22), 10, -1);
    check_rx_a("t5_ovr", 8'h11, 1'b0, 1'b0, 1'b1);
    ack(0);
    check_eq("t5_ack_valid", {31'h0, a_rx_valid}, 32'h0);
    check_eq("t5_ack_ovr", {31'h0, a_ovr}, 32'h0);
    drive_line(0, f8(8'h44), 10, -1);
    check_rx_a("t5_44", 8'h44, 1'b0, 1'b0, 1'b0);
    fork
      drive_line(0, f8(8'h33), 10, -1);
      begin
        repeat (156) @(negedge clk);
        a_rx_ack = 1'b1;
        @(negedge clk);
        a_rx_ack = 1'b0;
      end
    join
    check_rx_a("t5_coincide", 8'h33, 1'b0, 1'b0, 1'b0);

    // reset mid-frame with rx_valid still set from the last frame
    a_loop = 1'b1;
    @(negedge clk);
    a_tx_data = 8'h00;
    a_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("t6_pre_txd", {31'h0, a_txd}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    $display("rst t6 txd=%0b ready=%0b valid=%0b", a_txd, a_tx_ready, a_rx_valid);
    check_eq("t6_txd", {31'h0, a_txd}, 32'h1);
    check_eq("t6_ready", {31'h0, a_tx_ready}, 32'h1);
    check_eq("t6_valid", {31'h0, a_rx_valid}, 32'h0);
    check_eq("t6_data", {24'h0, a_rx_data}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tx_and_watch(0, 8'hFF, f8(8'hFF), 10, 160, "t6");
    check_rx_a("t6_rx", 8'hFF, 1'b0, 1'b0, 1'b0);
    a_loop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised successor to the fixed 8N1 UART. One core holds the baud tick generator, transmitter and receiver.
- Adds the following over the fixed UART:
  - configurable data width, parity and stop bits
  - valid/ready TX handshake
  - RX input synchroniser with majority-vote sampling
  - false-start rejection
  - frame, parity and overrun error reporting
  - break handling
- Sits between the SPI/control fabric and the board UART pins.

Parameters:
CLK_FREQ, 25000000, input clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, ticks per bit; even, 8..32
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tx_data  in  DATA_BITS  byte to send, LSB first
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter idle, accepts a word
txd  out  1  serial output, idle high
rxd  in  1  asynchronous serial input
rx_data  out  DATA_BITS  last received word
rx_valid  out  1  rx_data/error flags valid, held until rx_ack
rx_ack  in  1  consumer has taken rx_data; clears rx_valid
rx_frame_err  out  1  first stop bit sampled low (qualified by rx_valid)
rx_parity_err  out  1  parity mismatch (qualified by rx_valid; 0 when PARITY=0)
rx_overrun  out  1  sticky: a frame completed while rx_valid=1; cleared by rx_ack

Behaviour:
Reset:
- Synchronous reset, checked on every clk edge and overriding everything.
- Output values in reset: txd=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags=0.
- Both FSMs go to IDLE and all counters clear, including mid-frame. txd returns high the cycle after rst is sampled.

Tick generator:
- DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, minimum 1. tick pulses 1 clk every DIV clks.
- Counter width is $clog2(DIV+1). The counter free-runs from reset.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- tx_ready=1 only in IDLE.
- Transfer occurs when tx_valid && tx_ready. tx_data is latched into a shift register and the FSM enters START.
- A bit counter restarts at transfer. Each bit holds txd for exactly OVERSAMPLE ticks.
- Sequence: START drives 0 → DATA drives DATA_BITS bits LSB first → PARITY (skipped if PARITY=0; odd: XOR of data inverted, even: XOR of data) → STOP drives 1 for STOP_BITS bit periods → IDLE.
- txd goes low no later than the first tick after transfer. tx_ready rises in the cycle following the last stop tick.
- tx_data changes while busy are ignored. A tx_valid held high in IDLE back-to-back starts the next frame immediately.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
- rxd passes through a 2-flop synchroniser; rxs is the synchronised signal. All decisions use rxs.
- IDLE: rxs==0 on a tick → START, sample counter=0.
- Each bit uses 3 samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 after the bit edge. The bit value is the 2-of-3 majority.
- START: majority 1 → false start, return to IDLE with no output. Majority 0 → DATA.
- DATA: DATA_BITS bits are shifted in LSB first.
- PARITY: the received bit is compared with the computed parity.
- STOP: only the first stop bit is checked. The decision is made at the mid-bit sample so a new start edge can be caught.
  - Stop bit 1 → IDLE.
  - Stop bit 0 → frame_err=1, then WAIT_HIGH, which stays until rxs==1 on a tick and then goes to IDLE (a break yields one frame only).

Delivery (cycle after the stop decision):
- If rx_valid==0: load rx_data and both error flags; rx_valid=1.
- If rx_valid==1: data is discarded, rx_data is unchanged, rx_overrun=1.

rx_ack:
- rx_ack when rx_valid=1 clears rx_valid and rx_overrun next cycle.
- If rx_ack coincides with a delivery, the new frame is loaded, rx_valid stays 1 and no overrun is raised.
- rx_ack while rx_valid=0 is ignored.

Test Plan:
Sim parameters: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16, so DIV=1 and the bit period is 16 clk.
1. 8N1: send tx_data=0xA5 → txd waveform 0,1,0,1,0,0,1,0,1,1 (each 16 clk). tx_ready low for 160 clk. Loop txd→rxd gives rx_data=0xA5, rx_valid=1, no errors.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x53 → parity bit 0, stop high for 32 clk. RX delivers 0x53, parity_err=0. Repeat with the parity bit flipped on the line → parity_err=1.
3. Glitch: rxd low for 4 clk then high → no rx_valid, FSM back in IDLE. A 1-clk spike in the middle of a data bit is rejected by the majority vote, giving the correct data.
4. Framing/break: stop bit driven 0 → frame_err=1. Hold rxd low for 100 bit periods → exactly one rx_valid, and the next clean frame 0x3C is received correctly.
5. Overrun: two frames 0x11, 0x22 without rx_ack → rx_data=0x11, rx_overrun=1. rx_ack → rx_valid=0, rx_overrun=0. A third frame 0x33 with rx_ack coinciding with delivery → rx_data=0x33, rx_overrun=0.
6. Reset mid-frame: assert rst during DATA of a TX and an RX frame → next cycle txd=1, tx_ready=1, rx_valid=0. After reset a new 0xFF frame transfers correctly.
